// File: rtl/spi_master_arbiter_if.sv
// Requester-side handshake and SPI bus signals of the arbitrated SPI master.
// The master modport is the arbiter side; the slave modport is the requester/bus side.
interface spi_master_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] tx_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          busy;
  logic                          done;
  logic [DATA_WIDTH-1:0]         rx_data;
  logic                          sclk;
  logic                          cs_n;
  logic                          mosi;
  logic                          miso;

  modport master (
    input  req, tx_data, miso,
    output gnt, busy, done, rx_data, sclk, cs_n, mosi
  );

  modport slave (
    output req, tx_data, miso,
    input  gnt, busy, done, rx_data, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// SPI master shared by NUM_REQ requesters with round-robin arbitration;
// one full-duplex DATA_WIDTH-bit MSB-first transfer per grant.
module spi_master_arbiter #(
  parameter int unsigned CLK_DIV    = 5,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter bit          CPOL       = 1'b1,
  parameter bit          CPHA       = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  spi_master_arbiter_if.master bus
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned EW = $clog2(2 * DATA_WIDTH + 1);
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [EW-1:0]         edge_cnt;
  logic [PW-1:0]         ptr;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;

  logic                  win_found;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         cand;
  logic [NUM_REQ-1:0]    win_oh;
  logic [DATA_WIDTH-1:0] win_word;

  logic                  cnt_last;
  logic [EW-1:0]         nxt_edge;
  logic                  leading;
  logic                  sample_edge;
  logic                  shift_edge;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    win_oh    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PW'((32'(ptr) + i) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_oh[win_idx] = 1'b1;
    win_word = bus.tx_data[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
  end

  assign cnt_last    = (cnt == CNT_LAST);
  assign nxt_edge    = edge_cnt + 1'b1;
  assign leading     = nxt_edge[0];
  assign sample_edge = CPHA ? ~leading : leading;
  // With CPHA=1 the MSB is already on mosi, so the first leading edge does not shift.
  assign shift_edge  = CPHA ? (leading && (nxt_edge != EW'(1))) : ~leading;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      edge_cnt    <= '0;
      ptr         <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bus.gnt     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rx_data <= '0;
      bus.sclk    <= CPOL;
      bus.cs_n    <= 1'b1;
      bus.mosi    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= SETUP;
            cnt      <= '0;
            edge_cnt <= '0;
            rx_sr    <= '0;
            bus.gnt  <= win_oh;
            bus.busy <= 1'b1;
            bus.cs_n <= 1'b0;
            ptr      <= (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
            // tx_sr holds the bits still to follow the one currently on mosi.
            {bus.mosi, tx_sr} <= {win_word, 1'b0};
          end
        end
        SETUP, XFER: begin
          if (cnt_last) begin
            cnt      <= '0;
            bus.sclk <= ~bus.sclk;
            edge_cnt <= nxt_edge;
            if (sample_edge) rx_sr <= {rx_sr[DATA_WIDTH-2:0], bus.miso};
            if (shift_edge) {bus.mosi, tx_sr} <= {tx_sr, 1'b0};
            state <= (nxt_edge == EDGE_LAST) ? HOLD : XFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_last) begin
            cnt         <= '0;
            bus.cs_n    <= 1'b1;
            bus.mosi    <= 1'b0;
            bus.gnt     <= '0;
            bus.done    <= 1'b1;
            bus.rx_data <= rx_sr;
            state       <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt_last) begin
            cnt      <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

SPI master that shares one SPI bus between `NUM_REQ` on-chip requesters with round-robin arbitration. It drives `sclk`, `cs_n` and `mosi`, samples `miso`, and runs one full-duplex `DATA_WIDTH`-bit transfer per grant. Its bus-side SPI mode and `sclk` rate match the team's SPI slave blocks, so the pair can be looped back on-chip.

## Interface
- `CLK_DIV`, 5: `clk` cycles per `sclk` half-period. Legal range is ≥4, so a 2-flop-synchronised slave settles MISO before the sample edge.
- `DATA_WIDTH`, 8: bits per transfer, MSB first. Legal range is ≥2.
- `NUM_REQ`, 4: number of requesters.
- `CPOL`, 1: `sclk` idle level.
- `CPHA`, 1: 0 = sample on leading edge; 1 = sample on trailing edge.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NUM_REQ`: request level. Held high until the matching `done`.
- `tx_data` in `NUM_REQ*DATA_WIDTH`: word for requester i is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `gnt` out `NUM_REQ`: one-hot grant, high for the whole transaction.
- `busy` out 1: high from grant until return to IDLE.
- `done` out 1: one-cycle pulse at transaction end.
- `rx_data` out `DATA_WIDTH`: word received from `miso`. Valid from `done` onward and held until the next `done`.
- `sclk` out 1, `cs_n` out 1, `mosi` out 1: SPI bus outputs.
- `miso` in 1: SPI bus input.

## Operation
- Reset values:
  - `gnt`=0, `busy`=0, `done`=0, `rx_data`=0.
  - `sclk`=`CPOL`, `cs_n`=1, `mosi`=0.
  - Round-robin pointer = 0, so `req[0]` has highest priority first.
  - State = IDLE.
- States: IDLE → SETUP → XFER → HOLD → GAP → IDLE.
- IDLE, any `req` high:
  - Winner = first set bit searching from pointer, ascending with wrap.
  - Latch the winner's `tx_data` into the shift register.
  - Set `gnt`, `busy`, `cs_n`=0.
  - Pointer ← winner+1 mod `NUM_REQ`.
  - `mosi` = latched MSB.
- SETUP: `CLK_DIV` cycles, `sclk`=`CPOL`.
- XFER:
  - `sclk` toggles every `CLK_DIV` cycles, giving exactly 2·`DATA_WIDTH` edges.
  - Odd edges are leading, even edges are trailing.
  - Sample edge shifts `miso` into the receive register LSB.
  - Shift edge shifts the transmit register left, so `mosi` = new MSB.
  - CPHA=0: sample = leading, shift = trailing.
  - CPHA=1: shift = leading except the first leading edge (MSB already on `mosi`), sample = trailing.
- HOLD: `CLK_DIV` cycles, `sclk`=`CPOL`, `cs_n` still 0.
  - On exit: `cs_n`=1, `gnt`=0, `done`=1, `rx_data` ← receive register.
- GAP: `CLK_DIV` cycles with `cs_n`=1, so the slave sees the deselect. Then IDLE, `busy`=0.
- `req` changes after grant are ignored:
  - A dropped `req` still completes its transaction.
  - New requests wait for IDLE.
- `tx_data` changes after grant are ignored.
- `mosi`=0 whenever `cs_n`=1.
- Reset mid-transaction aborts on the next edge: `cs_n`=1, `sclk`=`CPOL`, `gnt`=0, no `done`, `rx_data` cleared.

## Timing
- Let IDLE with `req` high be cycle T.
  - `gnt`/`cs_n`/`busy` change at T+1.
  - `sclk` edge k (1..2·`DATA_WIDTH`) at T+1+k·`CLK_DIV`.
  - `done`/`cs_n`↑ at T+1+(2·`DATA_WIDTH`+1)·`CLK_DIV`.
  - IDLE at T+1+(2·`DATA_WIDTH`+2)·`CLK_DIV`.
- Defaults: edges at T+6..T+81, `done` at T+86, IDLE at T+91.
  - Back-to-back grant at T+92.
  - `cs_n` high for exactly 6 cycles between back-to-back transfers.
- `done` and `gnt` deassert in the same cycle.
- `busy` stays high through GAP.

## Test plan
- Mode 3, requester 0, `tx_data`=0xA5, `miso` model returns 0x3C:
  - `mosi` on trailing edges reads 1,0,1,0,0,1,0,1.
  - `rx_data`=0x3C.
  - `done` exactly at T+86, 16 `sclk` edges total.
- `req`=4'b1111 held continuously → grant order 0,1,2,3,0; `gnt` always one-hot; GAP = 5 cycles.
- Requester 2 only, then `req[1]` raised mid-transfer and `req[2]` dropped at edge 4:
  - Transfer 2 completes with `done`.
  - Requester 1 is granted at the next IDLE.
- `rst` pulsed at edge 7 → next cycle `cs_n`=1, `sclk`=`CPOL`, `gnt`=0, `busy`=0, no `done`, `rx_data`=0. The pointer restarts at requester 0.
- CPOL=0, CPHA=0, `CLK_DIV`=4, loopback to the team SPI slave (mode 0) with slave `data_in`=0x96 and master word 0x5A:
  - Master `rx_data`=0x96.
  - Slave `data_out`=0x5A and `data_valid` asserted.
